// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, combinational imem address, IF/ID pipeline register.
// Optional IF_PERF_CNT_EN adds 32-bit fetch and stall counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        misalign_err_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_pc_plus4;
  logic [31:0] r_if_id_instr;
  logic        r_if_id_valid;
  logic        r_misalign_err;

  logic [31:0] w_pc_plus4;
  logic        w_bubble;
  logic        w_fetch;

  // Downstream contract: if_id_valid_o marks a real instruction; a bubble
  // (flush or redirect) overrides stall, and stall freezes PC and IF/ID together.
  always_comb begin
    w_pc_plus4 = r_pc + 32'd4;
    w_bubble   = flush_i | redirect_valid_i;
    w_fetch    = ~w_bubble & ~stall_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc             <= RESET_PC;
      r_if_id_pc       <= 32'd0;
      r_if_id_pc_plus4 <= 32'd0;
      r_if_id_instr    <= NOP_INSTR;
      r_if_id_valid    <= 1'b0;
      r_misalign_err   <= 1'b0;
    end else begin
      if (redirect_valid_i) begin
        r_pc <= {redirect_pc_i[31:2], 2'b00};
      end else if (!stall_i) begin
        r_pc <= w_pc_plus4;
      end

      // Bubbles keep pc/pc_plus4 so the squashed slot still carries a sane address.
      if (w_bubble) begin
        r_if_id_instr <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
      end else if (w_fetch) begin
        r_if_id_instr    <= imem_instr_i;
        r_if_id_pc       <= r_pc;
        r_if_id_pc_plus4 <= w_pc_plus4;
        r_if_id_valid    <= 1'b1;
      end

      if (redirect_valid_i && (redirect_pc_i[1:0] != 2'b00)) begin
        r_misalign_err <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch_cnt <= 32'd0;
      r_perf_stall_cnt <= 32'd0;
    end else begin
      if (w_fetch) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (stall_i && !redirect_valid_i) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch_cnt;
  assign perf_stall_cnt_o = r_perf_stall_cnt;
`endif

  assign imem_addr_o      = r_pc;
  assign if_id_pc_o       = r_if_id_pc;
  assign if_id_pc_plus4_o = r_if_id_pc_plus4;
  assign if_id_instr_o    = r_if_id_instr;
  assign if_id_valid_o    = r_if_id_valid;
  assign misalign_err_o   = r_misalign_err;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed vectors push hand-computed IF state,
// a monitor pops one entry per clock edge and compares.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        misalign_err_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  // Packed expectation: {addr, instr, pc, pc_plus4, valid, misalign}
  logic [129:0] exp_q[$];
  int n_vec;
  int n_err;
  int n_cmp;
  int vec_id;

  if_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_instr_i     (imem_instr_i),
    .if_id_pc_o       (if_id_pc_o),
    .if_id_pc_plus4_o (if_id_pc_plus4_o),
    .if_id_instr_o    (if_id_instr_o),
    .if_id_valid_o    (if_id_valid_o),
    .misalign_err_o   (misalign_err_o)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  // Instruction memory: word[k] = k+1, combinational read.
  assign imem_instr_i = (imem_addr_o >> 2) + 32'd1;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp32(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic check_vec(input int id, input logic [129:0] e);
    n_vec++;
    cmp32("imem_addr", id, imem_addr_o, e[129:98]);
    cmp32("if_id_instr", id, if_id_instr_o, e[97:66]);
    cmp32("if_id_pc", id, if_id_pc_o, e[65:34]);
    cmp32("if_id_pc_plus4", id, if_id_pc_plus4_o, e[33:2]);
    cmp32("if_id_valid", id, {31'd0, if_id_valid_o}, {31'd0, e[1]});
    cmp32("misalign_err", id, {31'd0, misalign_err_o}, {31'd0, e[0]});
  endtask

  // Driver: apply inputs for the next edge and push the state expected after it.
  task automatic drive(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                       input logic [31:0] e_addr, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic [31:0] e_pc4,
                       input logic e_valid, input logic e_mis);
    stall_i          = st;
    flush_i          = fl;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    exp_q.push_back({e_addr, e_instr, e_pc, e_pc4, e_valid, e_mis});
  endtask

  task automatic vec(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                     input logic [31:0] e_addr, input logic [31:0] e_instr,
                     input logic [31:0] e_pc, input logic [31:0] e_pc4,
                     input logic e_valid, input logic e_mis);
    @(negedge clk);
    drive(st, fl, rv, rpc, e_addr, e_instr, e_pc, e_pc4, e_valid, e_mis);
  endtask

  // Monitor: one popped expectation per clock edge, sampled 2 time units after it.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        check_vec(vec_id, exp_q.pop_front());
        vec_id++;
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; n_cmp = 0; vec_id = 0;
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    check_vec(-1, {32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0});

    // Sequential fetch
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h4, 32'd1, 32'h0, 32'h4, 1, 0);
    vec(0, 0, 0, 32'h0, 32'h8, 32'd2, 32'h4, 32'h8, 1, 0);
    // Stall three cycles at PC=8
    vec(1, 0, 0, 32'h0, 32'h8, 32'd2, 32'h4, 32'h8, 1, 0);
    vec(1, 0, 0, 32'h0, 32'h8, 32'd2, 32'h4, 32'h8, 1, 0);
    vec(1, 0, 0, 32'h0, 32'h8, 32'd2, 32'h4, 32'h8, 1, 0);
    vec(0, 0, 0, 32'h0, 32'hC, 32'd3, 32'h8, 32'hC, 1, 0);
    vec(0, 0, 0, 32'h0, 32'h10, 32'd4, 32'hC, 32'h10, 1, 0);
    // Redirect to 0x40 at PC=0x10
    vec(0, 0, 1, 32'h40, 32'h40, NOP, 32'hC, 32'h10, 0, 0);
    vec(0, 0, 0, 32'h0, 32'h44, 32'd17, 32'h40, 32'h44, 1, 0);
    // Redirect with stall
    vec(1, 0, 1, 32'h80, 32'h80, NOP, 32'h40, 32'h44, 0, 0);
    vec(0, 0, 0, 32'h0, 32'h84, 32'd33, 32'h80, 32'h84, 1, 0);
    // Flush with stall, then plain flush
    vec(1, 1, 0, 32'h0, 32'h84, NOP, 32'h80, 32'h84, 0, 0);
    vec(0, 0, 0, 32'h0, 32'h88, 32'd34, 32'h84, 32'h88, 1, 0);
    vec(0, 1, 0, 32'h0, 32'h8C, NOP, 32'h84, 32'h88, 0, 0);
    vec(0, 0, 0, 32'h0, 32'h90, 32'd36, 32'h8C, 32'h90, 1, 0);
    // Misaligned redirect: aligned fetch continues, flag sticks
    vec(0, 0, 1, 32'h46, 32'h44, NOP, 32'h8C, 32'h90, 0, 1);
    vec(0, 0, 0, 32'h0, 32'h48, 32'd18, 32'h44, 32'h48, 1, 1);
    for (int i = 0; i < 10; i++) begin
      vec(0, 0, 0, 32'h0, 32'h4C + 32'(4 * i), 32'd19 + 32'(i), 32'h48 + 32'(4 * i),
          32'h4C + 32'(4 * i), 1, 1);
    end
    // PC wrap from 0xFFFF_FFFC
    vec(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 32'h6C, 32'h70, 0, 1);
    vec(0, 0, 0, 32'h0, 32'h0, 32'h4000_0000, 32'hFFFF_FFFC, 32'h0, 1, 1);
    vec(0, 0, 0, 32'h0, 32'h4, 32'd1, 32'h0, 32'h4, 1, 1);
    @(negedge clk);
    stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0;
`ifdef IF_PERF_CNT_EN
    cmp32("perf_fetch_cnt", vec_id, perf_fetch_cnt_o, 32'd21);
    cmp32("perf_stall_cnt", vec_id, perf_stall_cnt_o, 32'd4);
`endif

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_vec(-2, {32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0});
`ifdef IF_PERF_CNT_EN
    cmp32("perf_fetch_rst", -2, perf_fetch_cnt_o, 32'd0);
    cmp32("perf_stall_rst", -2, perf_stall_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h4, 32'd1, 32'h0, 32'h4, 1, 0);

    // Drain the scoreboard within a bounded number of edges
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RV32I pipeline: holds the program counter, drives it as the word address into `InstructionMemory` (combinational read), and captures the returned instruction into the IF/ID pipeline register. It applies stall, flush and branch/jump redirect from the hazard and EX logic. The decode stage consumes its IF/ID outputs.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`) placed in IF/ID on flush and reset.
- `clk`  in  1: clock. Every register updates on the rising edge.
- `rst_n`  in  1: reset. Asynchronous and active-low.
- `stall_i`  in  1: hold request from the hazard unit. Freezes PC and IF/ID.
- `flush_i`  in  1: squash request. IF/ID loads a bubble.
- `redirect_valid_i`  in  1: taken branch or jump from EX.
- `redirect_pc_i`  in  32: redirect target.
- `imem_addr_o`  out  32: current PC. Connects to instruction memory `pc_address`.
- `imem_instr_i`  in  32: instruction returned by memory (`instr_out`).
- `if_id_pc_o`  out  32: PC of the instruction held in IF/ID.
- `if_id_pc_plus4_o`  out  32: that PC + 4, for JAL/JALR link.
- `if_id_instr_o`  out  32: instruction held in IF/ID.
- `if_id_valid_o`  out  1: IF/ID holds a real instruction (0 = bubble).
- `misalign_err_o`  out  1: sticky flag. Set when a redirect target has non-zero `[1:0]`.
- `perf_fetch_cnt_o`  out  32: only when `IF_PERF_CNT_EN` is defined.
- `perf_stall_cnt_o`  out  32: only when `IF_PERF_CNT_EN` is defined.

## Operation
- `imem_addr_o` equals the PC register directly, with no logic in the path.
- **PC update priority** (highest first):
  - `redirect_valid_i` → PC ← `{redirect_pc_i[31:2],2'b00}`.
  - `stall_i` → PC holds.
  - otherwise → PC ← PC+4.
- **IF/ID update priority** (highest first):
  - `flush_i | redirect_valid_i` → bubble: instr=`NOP_INSTR`, valid=0, pc and pc_plus4 hold.
  - `stall_i` → IF/ID holds all fields.
  - otherwise → instr=`imem_instr_i`, pc=PC, pc_plus4=PC+4, valid=1.
- **Arithmetic:** PC+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- **Misaligned redirect:** if `redirect_valid_i` and `redirect_pc_i[1:0]!=0`, set `misalign_err_o`. It stays set until reset. Fetch continues from the aligned target.
- **Simultaneous events:**
  - Redirect with stall: the redirect wins for both PC and IF/ID.
  - Flush with stall and no redirect: PC holds, IF/ID loads a bubble.
- **Reset values:**
  - PC=`RESET_PC`.
  - if_id_instr=`NOP_INSTR`, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0.
  - misalign_err=0, counters=0.
- **Reset mid-operation:** all registers clear immediately when `rst_n` falls. Fetch of `RESET_PC` is presented on `imem_addr_o` the same cycle. The first edge after `rst_n` rises captures the instruction at `RESET_PC` with valid=1, unless stalled or flushed.

## Timing
- `imem_addr_o` → `imem_instr_i` is combinational within one cycle. The instruction for PC appears on the IF/ID outputs after the next rising edge (1-cycle latency).
- Redirect penalty:
  - The edge that samples `redirect_valid_i` loads the target PC and inserts one bubble into IF/ID.
  - The target instruction reaches IF/ID one edge later.
- A stall of N cycles holds PC and IF/ID for exactly N edges. No instruction is lost or duplicated.
- All outputs are registered except `imem_addr_o`, which is a direct register output.

## Configuration
- **`IF_PERF_CNT_EN` defined:** two 32-bit wrap-around counters are present.
  - `perf_fetch_cnt_o` increments on each edge where IF/ID loads a valid instruction.
  - `perf_stall_cnt_o` increments on each edge where `stall_i=1` and `redirect_valid_i=0`.
  - Both reset to 0.
- **`IF_PERF_CNT_EN` undefined:** the counter registers and both ports are absent. All other behaviour is identical.

## Test plan
- **Reset and sequential fetch:** reset release, memory word[k]=k+1, no stall → `imem_addr_o` = 0,4,8. IF/ID shows instr 1,2,3 with pc 0,4,8, pc_plus4 4,8,12, valid=1 from the first edge.
- **Stall:** `stall_i` high 3 cycles at PC=8 → PC stays 8 and IF/ID holds instr 2 / pc 4 for 3 edges. The next edge loads instr 3 / pc 8. `perf_stall_cnt_o`=3 when `IF_PERF_CNT_EN` is defined.
- **Redirect:** redirect to 32'h40 while PC=0x10 → next edge PC=0x40, IF/ID=NOP with valid=0. The following edge gives IF/ID pc=0x40, valid=1.
- **Redirect with stall, and flush with stall:**
  - Redirect+stall together → redirect applied and a bubble inserted.
  - Flush+stall with no redirect → PC holds and IF/ID becomes NOP, valid=0.
- **Misaligned redirect:** target 32'h0000_0046 → PC=0x44 and `misalign_err_o`=1. The flag persists through 10 further cycles and clears only on `rst_n`=0.
- **Wrap and async reset:** PC forced via redirect to 0xFFFF_FFFC → next PC=0. Then `rst_n` asserted mid-cycle → all outputs reach reset values before the next edge.
